// File: rtl/ceespu_execute_mc_if.sv
// ceespu_execute_mc_if: instruction-in / writeback-out bundle for the ceespu execute stage.
interface ceespu_execute_mc_if #(
  parameter int XLEN = 32,
  parameter int PCW = 14,
  parameter int REGW = 5
);
  logic I_valid;
  logic [REGW-1:0] I_selD;
  logic I_we;
  logic [3:0] I_aluop;
  logic I_branch;
  logic [2:0] I_branchop;
  logic [1:0] I_selWb;
  logic [1:0] I_selCin;
  logic [3:0] I_selMem;
  logic [XLEN-1:0] I_dataA;
  logic [XLEN-1:0] I_dataB;
  logic [XLEN-1:0] I_memA;
  logic [PCW-1:0] I_PC;
  logic [REGW-1:0] O_selD;
  logic O_we;
  logic [XLEN-1:0] O_dataD;
  logic O_busy;
  logic O_branch;
  modport master (
    output I_valid, I_selD, I_we, I_aluop, I_branch, I_branchop, I_selWb, I_selCin, I_selMem,
    output I_dataA, I_dataB, I_memA, I_PC,
    input O_selD, O_we, O_dataD, O_busy, O_branch
  );
  modport slave (
    input I_valid, I_selD, I_we, I_aluop, I_branch, I_branchop, I_selWb, I_selCin, I_selMem,
    input I_dataA, I_dataB, I_memA, I_PC,
    output O_selD, O_we, O_dataD, O_busy, O_branch
  );
endinterface

// File: rtl/ceespu_execute_mc.sv
// ceespu_execute_mc: execute stage with ALU, branch compare, load alignment and iterative multiplier.
// Defining CEESPU_EXECUTE_DIV_EN adds iterative DIVU/REMU on the same multi-cycle state machine.
module ceespu_execute_mc #(
  parameter int XLEN = 32,
  parameter int PCW = 14,
  parameter int REGW = 5
) (
  input logic I_clk,
  input logic I_rst,
  ceespu_execute_mc_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, dat_q, dat_d;
  logic [2*XLEN-1:0] p_q, p_d, mul_p, step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REGW-1:0] sel_q, sel_d;
  logic hi_q, hi_d, carry_q, carry_d, we_q, we_d;
  logic cin, cond, is_mc, op_div, busy;
  logic [XLEN:0] sum, mul_hi;
  logic [XLEN-1:0] opb, alu, ld, wb, res;
  logic [SW-1:0] sh;
  logic [7:0] b8;
  logic [15:0] h16;
  logic [31:0] ld32;
  assign cin = bus.I_selCin == 2'd0 ? 1'b0 : bus.I_selCin == 2'd1 ? carry_q :
               bus.I_selCin == 2'd2 ? ~carry_q : 1'b1;
  assign opb = bus.I_aluop == 4'd1 ? ~bus.I_dataB : bus.I_dataB;
  assign sum = {1'b0, bus.I_dataA} + {1'b0, opb} + (XLEN+1)'(cin);
  assign sh = bus.I_dataB[SW-1:0];
  always_comb begin
    alu = '0;
    case (bus.I_aluop)
      4'd0, 4'd1: alu = sum[XLEN-1:0];
      4'd2: alu = bus.I_dataA & bus.I_dataB;
      4'd3: alu = bus.I_dataA | bus.I_dataB;
      4'd4: alu = bus.I_dataA ^ bus.I_dataB;
      4'd5: alu = bus.I_dataA << sh;
      4'd6: alu = bus.I_dataA >> sh;
      4'd7: alu = XLEN'($signed(bus.I_dataA) >>> sh);
      default: alu = '0;
    endcase
  end
  always_comb begin
    cond = 1'b1;
    case (bus.I_branchop)
      3'd0: cond = bus.I_dataA == bus.I_dataB;
      3'd1: cond = bus.I_dataA != bus.I_dataB;
      3'd2: cond = $signed(bus.I_dataA) < $signed(bus.I_dataB);
      3'd3: cond = $signed(bus.I_dataA) >= $signed(bus.I_dataB);
      3'd4: cond = bus.I_dataA < bus.I_dataB;
      3'd5: cond = bus.I_dataA >= bus.I_dataB;
      3'd6: cond = carry_q;
      default: cond = 1'b1;
    endcase
  end
  assign bus.O_branch = bus.I_valid & bus.I_branch & cond;
  // Lanes always come from the low 32 bits; extension to XLEN happens last.
  assign b8 = bus.I_memA[8*bus.I_selMem[1:0] +: 8];
  assign h16 = bus.I_selMem[0] ? bus.I_memA[31:16] : bus.I_memA[15:0];
  assign ld32 = bus.I_selMem[2] ? {{24{bus.I_selMem[3] & b8[7]}}, b8} :
                bus.I_selMem[1] ? {{16{bus.I_selMem[3] & h16[15]}}, h16} : bus.I_memA[31:0];
  assign ld = bus.I_selMem[3] ? XLEN'($signed(ld32)) : XLEN'(ld32);
  assign wb = bus.I_selWb == 2'd0 ? alu : bus.I_selWb == 2'd1 ? ld :
              bus.I_selWb == 2'd2 ? XLEN'(bus.I_PC) : bus.I_dataB;
  assign mul_hi = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_p = {mul_hi, p_q[XLEN-1:1]};
  assign res = hi_q ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
`ifdef CEESPU_EXECUTE_DIV_EN
  logic div_q, div_d;
  logic [XLEN:0] shf, dif;
  logic [2*XLEN-1:0] div_p;
  assign shf = p_q[2*XLEN-1:XLEN-1];
  assign dif = shf - {1'b0, a_q};
  assign div_p = dif[XLEN] ? {p_q[2*XLEN-2:0], 1'b0} : {dif[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
  assign is_mc = bus.I_aluop[3:2] == 2'b10;
  assign op_div = bus.I_aluop[1];
  assign div_d = state_q == IDLE ? op_div : div_q;
  assign step = div_q ? div_p : mul_p;
  always_ff @(posedge I_clk) div_q <= div_d;
`else
  assign is_mc = bus.I_aluop[3:1] == 3'b100;
  assign op_div = 1'b0;
  assign step = mul_p;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    p_d = p_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    carry_d = carry_q;
    we_d = 1'b0;
    dat_d = dat_q;
    sel_d = sel_q;
    busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.I_valid && is_mc) begin
          busy = 1'b1;
          state_d = RUN;
          a_d = op_div ? bus.I_dataB : bus.I_dataA;
          p_d = {{XLEN{1'b0}}, op_div ? bus.I_dataA : bus.I_dataB};
          cnt_d = CW'(XLEN);
          hi_d = bus.I_aluop[0];
        end else begin
          we_d = bus.I_valid & bus.I_we;
          dat_d = wb;
          sel_d = bus.I_selD;
          if (bus.I_valid && bus.I_aluop[3:1] == 3'b000) carry_d = sum[XLEN];
        end
      end
      RUN: begin
        busy = 1'b1;
        p_d = step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        we_d = bus.I_we;
        dat_d = res;
        sel_d = bus.I_selD;
      end
    endcase
  end
  always_ff @(posedge I_clk) begin
    a_q <= a_d;
    p_q <= p_d;
    cnt_q <= cnt_d;
    hi_q <= hi_d;
    if (I_rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      we_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      we_q <= we_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
    end
  end
  assign bus.O_busy = busy;
  assign bus.O_we = we_q;
  assign bus.O_dataD = dat_q;
  assign bus.O_selD = sel_q;
endmodule

// File: tb/tb_ceespu_execute_mc.sv
// tb_ceespu_execute_mc: directed and randomized checks of ceespu_execute_mc against a behavioural model.
module tb_ceespu_execute_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic carry_m = 1'b0;
`ifdef CEESPU_EXECUTE_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  ceespu_execute_mc_if #(.XLEN(32), .PCW(14), .REGW(5)) bus ();
  ceespu_execute_mc #(.XLEN(32), .PCW(14), .REGW(5)) dut (.I_clk(clk), .I_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [63:0] s;
    s = 64'd0;
    case (op)
      4'd0: s = 64'(a) + 64'(b) + 64'(c);
      4'd1: s = 64'(a) + (64'hFFFF_FFFF - 64'(b)) + 64'(c);
      4'd2: s = 64'(a & b);
      4'd3: s = 64'(a | b);
      4'd4: s = 64'(a ^ b);
      4'd5: s = 64'(a << (b % 32));
      4'd6: s = 64'(a >> (b % 32));
      4'd7: s = 64'(32'($signed(a) >>> (b % 32)));
      default: s = 64'd0;
    endcase
    return s[32:0];
  endfunction
  function automatic logic [31:0] ref_ld(input logic [3:0] s, input logic [31:0] m);
    logic [31:0] v;
    int w;
    if (s[2]) begin
      v = (m >> (8 * s[1:0])) & 32'hFF;
      w = 8;
    end else if (s[1]) begin
      v = (m >> (16 * s[0])) & 32'hFFFF;
      w = 16;
    end else begin
      v = m;
      w = 32;
    end
    if (s[3] && w < 32 && v[w-1]) v = v | (32'hFFFF_FFFF << w);
    return v;
  endfunction
  function automatic logic ref_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa < sb;
      3'd3: return sa >= sb;
      3'd4: return a < b;
      3'd5: return a >= b;
      3'd6: return c;
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic ref_cin(input logic [1:0] s, input logic c);
    return s == 2'd0 ? 1'b0 : s == 2'd1 ? c : s == 2'd2 ? !c : 1'b1;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic we, input logic [4:0] sd, input logic [3:0] op,
                     input logic [1:0] wb, input logic [1:0] cin, input logic [31:0] a, input logic [31:0] b);
    bus.I_valid = v;
    bus.I_we = we;
    bus.I_selD = sd;
    bus.I_aluop = op;
    bus.I_selWb = wb;
    bus.I_selCin = cin;
    bus.I_dataA = a;
    bus.I_dataB = b;
    bus.I_branch = 1'b0;
    bus.I_branchop = 3'd0;
    bus.I_selMem = 4'd0;
    bus.I_memA = 32'd0;
    bus.I_PC = 14'd0;
  endtask
  task automatic test_reset;
    drv(1'b0, 1'b0, 5'd0, 4'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    carry_m = 1'b0;
    total++;
    if (bus.O_we !== 1'b0 || bus.O_dataD !== 32'd0 || bus.O_selD !== 5'd0) begin
      bad++;
      $display("FAIL reset_regs: got we=%b d=%h sel=%0d want 0/0/0", bus.O_we, bus.O_dataD, bus.O_selD);
    end
    total++;
    if (bus.O_busy !== 1'b0 || bus.O_branch !== 1'b0) begin
      bad++;
      $display("FAIL reset_comb: got busy=%b br=%b want 0/0", bus.O_busy, bus.O_branch);
    end
  endtask
  task automatic test_add_carry;
    drv(1'b1, 1'b1, 5'd4, 4'd0, 2'd0, 2'd2, 32'd0, 32'd0);
    tick;
    total++;
    if (bus.O_dataD !== 32'd1) begin
      bad++;
      $display("FAIL add_notcarry_after_reset: got %h want 00000001", bus.O_dataD);
    end
    drv(1'b1, 1'b1, 5'd7, 4'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1);
    tick;
    total++;
    if (bus.O_dataD !== 32'd0 || bus.O_we !== 1'b1 || bus.O_selD !== 5'd7) begin
      bad++;
      $display("FAIL add_wrap: got d=%h we=%b sel=%0d want 00000000/1/7", bus.O_dataD, bus.O_we, bus.O_selD);
    end
    drv(1'b1, 1'b1, 5'd7, 4'd0, 2'd0, 2'd1, 32'd0, 32'd0);
    tick;
    total++;
    if (bus.O_dataD !== 32'd1) begin
      bad++;
      $display("FAIL add_carry_in: got %h want 00000001", bus.O_dataD);
    end
    drv(1'b1, 1'b1, 5'd2, 4'd1, 2'd0, 2'd3, 32'd5, 32'd7);
    tick;
    total++;
    if (bus.O_dataD !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL sub: got %h want fffffffe", bus.O_dataD);
    end
    carry_m = 1'b0;
  endtask
  task automatic test_multicycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sd, input logic [31:0] exp);
    int n;
    logic [31:0] prev;
    n = 0;
    prev = bus.O_dataD;
    drv(1'b1, 1'b1, sd, op, 2'd0, 2'd0, a, b);
    #1;
    while (bus.O_busy === 1'b1 && n < 100) begin
      if (n > 0 && (bus.O_we !== 1'b0 || bus.O_dataD !== prev)) begin
        total++;
        bad++;
        $display("FAIL mc_hold op=%0d cycle=%0d: got we=%b d=%h want 0/%h", op, n, bus.O_we, bus.O_dataD, prev);
      end
      tick;
      n++;
    end
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL mc_busy_len op=%0d: got %0d want 33", op, n);
    end
    tick;
    bus.I_valid = 1'b0;
    total++;
    if (bus.O_dataD !== exp || bus.O_we !== 1'b1 || bus.O_selD !== sd) begin
      bad++;
      $display("FAIL mc_result op=%0d: got d=%h we=%b sel=%0d want %h/1/%0d", op, bus.O_dataD, bus.O_we, bus.O_selD, exp, sd);
    end
  endtask
  task automatic test_mul;
    test_multicycle(4'd8, 32'd7, 32'd6, 5'd3, 32'd42);
    test_multicycle(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
  endtask
  task automatic test_load;
    logic [3:0] sels [4];
    logic [31:0] exps [4];
    sels = '{4'b1111, 4'b0011, 4'b1010, 4'b0100};
    exps = '{32'hFFFF_FF80, 32'h0000_80F0, 32'h0000_1234, 32'h0000_0034};
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 5'd9, 4'd0, 2'd1, 2'd0, 32'd0, 32'd0);
      bus.I_memA = 32'h80F0_1234;
      bus.I_selMem = sels[i];
      tick;
      total++;
      if (bus.O_dataD !== exps[i]) begin
        bad++;
        $display("FAIL load sel=%b: got %h want %h", sels[i], bus.O_dataD, exps[i]);
      end
    end
  endtask
  task automatic test_branch;
    drv(1'b1, 1'b0, 5'd0, 4'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1);
    bus.I_branch = 1'b1;
    bus.I_branchop = 3'd2;
    #1;
    total++;
    if (bus.O_branch !== 1'b1) begin
      bad++;
      $display("FAIL branch_lt: got %b want 1", bus.O_branch);
    end
    bus.I_branchop = 3'd4;
    #1;
    total++;
    if (bus.O_branch !== 1'b0) begin
      bad++;
      $display("FAIL branch_ltu: got %b want 0", bus.O_branch);
    end
    bus.I_branchop = 3'd2;
    bus.I_valid = 1'b0;
    #1;
    total++;
    if (bus.O_branch !== 1'b0) begin
      bad++;
      $display("FAIL branch_invalid: got %b want 0", bus.O_branch);
    end
    tick;
  endtask
  task automatic test_rst_mid_mul;
    drv(1'b1, 1'b1, 5'd0, 4'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1);
    tick;
    drv(1'b1, 1'b1, 5'd3, 4'd8, 2'd0, 2'd0, 32'd7, 32'd6);
    for (int i = 0; i < 10; i++) tick;
    rst = 1'b1;
    bus.I_valid = 1'b0;
    tick;
    rst = 1'b0;
    carry_m = 1'b0;
    total++;
    if (bus.O_busy !== 1'b0 || bus.O_we !== 1'b0 || bus.O_dataD !== 32'd0) begin
      bad++;
      $display("FAIL rst_mid_mul: got busy=%b we=%b d=%h want 0/0/0", bus.O_busy, bus.O_we, bus.O_dataD);
    end
    drv(1'b1, 1'b1, 5'd5, 4'd0, 2'd0, 2'd1, 32'd0, 32'd0);
    tick;
    total++;
    if (bus.O_dataD !== 32'd0) begin
      bad++;
      $display("FAIL rst_carry: got %h want 00000000", bus.O_dataD);
    end
    drv(1'b1, 1'b1, 5'd6, 4'd0, 2'd0, 2'd0, 32'd2, 32'd3);
    tick;
    total++;
    if (bus.O_dataD !== 32'd5 || bus.O_we !== 1'b1 || bus.O_selD !== 5'd6) begin
      bad++;
      $display("FAIL rst_then_add: got d=%h we=%b sel=%0d want 5/1/6", bus.O_dataD, bus.O_we, bus.O_selD);
    end
  endtask
  task automatic test_div;
`ifdef CEESPU_EXECUTE_DIV_EN
    test_multicycle(4'd10, 32'd100, 32'd7, 5'd8, 32'd14);
    test_multicycle(4'd11, 32'd100, 32'd7, 5'd8, 32'd2);
    test_multicycle(4'd10, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    test_multicycle(4'd11, 32'd5, 32'd0, 5'd8, 32'd5);
`else
    drv(1'b1, 1'b1, 5'd8, 4'd10, 2'd0, 2'd0, 32'd100, 32'd7);
    #1;
    total++;
    if (bus.O_busy !== 1'b0) begin
      bad++;
      $display("FAIL divu_nobusy: got %b want 0", bus.O_busy);
    end
    tick;
    total++;
    if (bus.O_dataD !== 32'd0 || bus.O_we !== 1'b1) begin
      bad++;
      $display("FAIL divu_disabled: got d=%h we=%b want 0/1", bus.O_dataD, bus.O_we);
    end
`endif
  endtask
  task automatic test_random;
    logic [3:0] op;
    logic [31:0] a, b, m, exp;
    logic [32:0] r;
    logic v, we, br;
    logic [1:0] wb, cs;
    logic [2:0] bo;
    logic [3:0] sm;
    logic [13:0] pc;
    logic [4:0] sd;
    for (int i = 0; i < 300; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'd8 || op == 4'd9 || (DIV && (op == 4'd10 || op == 4'd11)));
      v = ($urandom_range(0, 7) != 0);
      we = 1'($urandom);
      br = 1'($urandom);
      wb = 2'($urandom);
      cs = 2'($urandom);
      bo = 3'($urandom);
      sm = 4'($urandom);
      pc = 14'($urandom);
      sd = 5'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      m = $urandom;
      drv(v, we, sd, op, wb, cs, a, b);
      bus.I_branch = br;
      bus.I_branchop = bo;
      bus.I_selMem = sm;
      bus.I_memA = m;
      bus.I_PC = pc;
      #1;
      total++;
      if (bus.O_branch !== (v & br & ref_br(bo, a, b, carry_m)) || bus.O_busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_branch i=%0d op=%0d: got br=%b busy=%b want %b/0", i, bo, bus.O_branch, bus.O_busy, v & br & ref_br(bo, a, b, carry_m));
      end
      r = ref_alu(op, a, b, ref_cin(cs, carry_m));
      exp = wb == 2'd0 ? r[31:0] : wb == 2'd1 ? ref_ld(sm, m) : wb == 2'd2 ? 32'(pc) : b;
      tick;
      total++;
      if (bus.O_we !== (v & we) || (v && (bus.O_dataD !== exp || bus.O_selD !== sd))) begin
        bad++;
        $display("FAIL rand_wb i=%0d op=%0d wb=%0d: got d=%h we=%b sel=%0d want %h/%b/%0d", i, op, wb, bus.O_dataD, bus.O_we, bus.O_selD, exp, v & we, sd);
      end
      if (v && op < 4'd2) carry_m = r[32];
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic [63:0] p;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      p = 64'(a) * 64'(b);
      test_multicycle(4'(8 + (i % 2)), a, b, 5'(i + 10), (i % 2) ? p[63:32] : p[31:0]);
    end
    drv(1'b1, 1'b1, 5'd12, 4'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick;
    total++;
    if (bus.O_dataD !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL b2b_add1: got %h want fffffffe", bus.O_dataD);
    end
    drv(1'b1, 1'b1, 5'd13, 4'd0, 2'd0, 2'd1, 32'd1, 32'd1);
    tick;
    total++;
    if (bus.O_dataD !== 32'd3 || bus.O_selD !== 5'd13) begin
      bad++;
      $display("FAIL b2b_add2: got d=%h sel=%0d want 3/13", bus.O_dataD, bus.O_selD);
    end
    carry_m = 1'b0;
    bus.I_valid = 1'b0;
    tick;
  endtask
  initial begin
    test_reset;
    test_add_carry;
    test_mul;
    test_load;
    test_branch;
    test_rst_mid_mul;
    test_div;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ceespu_execute_mc.md
Name: ceespu_execute_mc

Overview:
Parametrised next-generation execute stage of the ceespu pipeline, sitting between decode/register-read and register writeback. It performs the single-cycle ALU ops, branch compare, load-data alignment and writeback selection. It adds an internal iterative multiplier with a valid/busy stall handshake and a carry flag usable as an ALU carry-in. Width of data, PC and register index is generic.

Parameters:
XLEN, 32, datapath width; power of 2, >= 32
PCW, 14, PC width; must be <= XLEN
REGW, 5, destination register index width

Ports:
I_clk  in  1  clock
I_rst  in  1  reset; synchronous, active-high
I_valid  in  1  instruction present this cycle
I_selD  in  REGW  destination register
I_we  in  1  instruction writes a register
I_aluop  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR, 8 MUL (low), 9 MULHU; 10 DIVU, 11 REMU with macro; others give 0
I_branch  in  1  instruction is a conditional branch
I_branchop  in  3  0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 carry set, 7 always
I_selWb  in  2  0 ALU, 1 load data, 2 PC, 3 operand B
I_selCin  in  2  0 zero, 1 carry, 2 not carry, 3 one
I_selMem  in  4  [3] sign-extend; [2:0] 0/1 word, 2/3 half lane 0/1, 4-7 byte lane 0-3
I_dataA  in  XLEN  operand A
I_dataB  in  XLEN  operand B
I_memA  in  XLEN  raw memory read word
I_PC  in  PCW  instruction PC
O_selD  out  REGW  registered destination
O_we  out  1  registered write enable
O_dataD  out  XLEN  registered writeback data
O_busy  out  1  stall request to upstream (combinational)
O_branch  out  1  branch taken (combinational)

Behaviour:
- Reset on a rising edge with I_rst=1: O_selD=0, O_we=0, O_dataD=0, carry flag=0, FSM=IDLE. Reset overrides a multiply in progress: no writeback, O_busy low from the next cycle.
- ADD: A+B+Cin. SUB: A+~B+Cin (plain SUB uses selCin=3). Carry flag latches the XLEN+1 carry-out on the edge, only for valid, non-busy ADD/SUB.
- Shifts use B[log2(XLEN)-1:0].
- Load lanes index the low 32 bits of I_memA; the result is zero- or sign-extended to XLEN.
- PC writeback is zero-extended.
- Single-cycle ops:
  - Result registers on the edge of the I_valid cycle.
  - O_we = I_valid & I_we.
  - Latency 1.
- Multi-cycle ops (MUL, MULHU, DIVU, REMU) use FSM IDLE -> RUN -> DONE.
  - IDLE: valid multi-cycle op raises O_busy in the same cycle. Operands are captured, bit counter = XLEN, go to RUN.
  - RUN: one shift-add (or restoring-divide) step per cycle. Counter decrements; at 1 go to DONE. O_busy=1.
  - DONE: O_busy=0. On the edge, O_dataD=result, O_we=I_we, O_selD=I_selD, return to IDLE.
  - O_busy is high for exactly XLEN+1 cycles.
  - Upstream holds all inputs stable while O_busy=1. The stage ignores input changes after capture, except I_rst.
- While O_busy=1, O_we registers 0 and O_dataD holds its value.
- I_valid=0: O_we registers 0; O_dataD and O_selD are don't-care but deterministic (still loaded).
- O_branch = I_valid & I_branch & cond. It is independent of O_busy; branch instructions are never multi-cycle.
- MULHU gives the upper XLEN bits of the unsigned 2*XLEN product. MUL gives the lower bits.

Optional Feature:
- Macro: CEESPU_EXECUTE_DIV_EN.
- Defined: aluop 10 (DIVU) and 11 (REMU) use the same FSM with restoring division and XLEN+1 busy cycles.
  - Divide by zero: quotient all ones, remainder = A.
- Undefined: aluop 10/11 are single-cycle, result 0, O_busy never asserted, no divider logic.

Test Plan:
- ADD A=0xFFFFFFFF, B=1, selCin=0 -> O_dataD=0 next cycle, carry=1. Then ADD A=0, B=0, selCin=1 -> O_dataD=1.
- MUL A=7, B=6, I_we=1, sel D=3, held stable -> O_busy high 33 cycles, O_we=0 meanwhile, then O_dataD=42, O_we=1, O_selD=3. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
- Load I_memA=0x80F01234: selMem=4'b1111 -> 0xFFFFFF80; 4'b0011 -> 0x000080F0; 4'b1010 -> 0x00001234.
- Branch LT A=0xFFFFFFFF, B=1, I_branch=1 -> O_branch=1. LTU same operands -> 0. I_valid=0 -> 0.
- Assert I_rst at cycle 10 of a MUL -> next cycle O_busy=0, O_we=0, O_dataD=0, carry=0. A following ADD 2+3 gives 5 with latency 1.
- With CEESPU_EXECUTE_DIV_EN: DIVU 100/7 -> 14, REMU -> 2, DIVU 5/0 -> 0xFFFFFFFF, each 33 busy cycles. Without the macro, DIVU -> 0 with O_busy never high.
